// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word-aligned
// fetches over a valid/ready channel, pairs in-order responses with their
// addresses and buffers them for decode. Redirects flush the buffer and
// mark every fetch already in flight as stale.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] pq_rd_q, pq_rd_d;
    logic [PW-1:0] pq_wr_q, pq_wr_d;

    logic [31:0] fifo_pc_q  [FIFO_DEPTH];
    logic [31:0] fifo_ins_q [FIFO_DEPTH];
    logic [31:0] pq_pc_q    [FIFO_DEPTH];

    logic        pop;
    logic        req_fire;
    logic        resp_fire;
    logic        push;
    logic        credit_ok;
    logic [CW:0] committed;

    // Credits count both in-flight fetches and buffered entries, so a
    // response always finds a free FIFO slot; a same-cycle pop frees one.
    assign pop       = if_valid & if_ready;
    assign committed = (CW + 1)'(outstanding_q) + (CW + 1)'(cnt_q) - (CW + 1)'(pop);
    assign credit_ok = (committed < DEPTH_W);

    assign imem_req_valid = ~rst & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp_fire = imem_resp_valid & (outstanding_q != '0);
    assign push      = resp_fire & ~redirect_valid & (drop_q == '0);

    assign if_valid       = (cnt_q != '0);
    assign if_pc          = if_valid ? fifo_pc_q[fifo_rd_q]  : 32'h0;
    assign if_instruction = if_valid ? fifo_ins_q[fifo_rd_q] : 32'h0;

    // Next-state computation for PC, counters and pointers.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        cnt_d         = cnt_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        pq_rd_d       = pq_rd_q;
        pq_wr_d       = pq_wr_q;

        if (req_fire && !resp_fire) begin
            outstanding_d = outstanding_q + ONE_C;
        end else if (!req_fire && resp_fire) begin
            outstanding_d = outstanding_q - ONE_C;
        end

        // The PC queue keeps running across redirects so stale responses
        // still consume their own entry.
        pq_wr_d = pq_wr_q + PW'(req_fire);
        pq_rd_d = pq_rd_q + PW'(resp_fire);

        if (redirect_valid) begin
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d    = outstanding_q - CW'(resp_fire);
            cnt_d     = '0;
            fifo_rd_d = '0;
            fifo_wr_d = '0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_fire && (drop_q != '0)) begin
                drop_d = drop_q - ONE_C;
            end
            cnt_d     = cnt_q + CW'(push) - CW'(pop);
            fifo_wr_d = fifo_wr_q + PW'(push);
            fifo_rd_d = fifo_rd_q + PW'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC_ALIGNED;
            outstanding_q <= '0;
            drop_q        <= '0;
            cnt_q         <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            pq_rd_q       <= '0;
            pq_wr_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            pq_rd_q       <= pq_rd_d;
            pq_wr_q       <= pq_wr_d;
        end
    end

    // Storage arrays; contents are only meaningful behind the valid pointers.
    always_ff @(posedge clk) begin
        if (!rst && req_fire) begin
            pq_pc_q[pq_wr_q] <= pc_q;
        end
        if (!rst && push) begin
            fifo_pc_q[fifo_wr_q]  <= pq_pc_q[pq_rd_q];
            fifo_ins_q[fifo_wr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The memory model returns each
// fetch address as its instruction word after a programmable latency.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_ready;

    instruction_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .if_ready        (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] acc_q[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_ins[$];
    int          cyc      = 0;
    int          lat      = 1;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
        checks++;
        if (idx >= q.size()) begin
            failures++;
            $display("FAIL %s: actual=missing required=%h", name, exp);
        end else if (q[idx] !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, q[idx], exp);
        end
    endtask

    // Drive this cycle's memory response, then let outputs settle.
    task automatic pre();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr;
            mq.delete(0);
        end
        #1;
    endtask

    // Record handshakes of this cycle and advance past the clock edge.
    task automatic post();
        mreq_t m;
        if (!rst && imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            acc_q.push_back(imem_req_addr);
        end
        if (!rst && if_valid && if_ready) begin
            log_pc.push_back(if_pc);
            log_ins.push_back(if_instruction);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        pre();
        post();
    endtask

    // Hold reset until the memory model has nothing left to return.
    task automatic drain();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && mq.size() > 0; i++) step();
        if (mq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", mq.size());
        end
        step();
        acc_q.delete();
        log_pc.delete();
        log_ins.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (log_pc.size() < n) begin
            failures++;
            $display("FAIL wait_log: actual=%0d entries required=%0d", log_pc.size(), n);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ir, input logic rv,
                                input logic [31:0] ra, input logic iv, input logic [31:0] pc);
        vec_t v;
        v.rst = r;  v.ifr = ir; v.rv = rv;
        v.ra  = ra; v.iv  = iv; v.pc = pc;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [23:0] pat;
        logic        prev_stall;
        logic [31:0] prev_addr;

        // Stream at 1-cycle latency, reset mid-stream, then backpressure.
        tbl.push_back(mk(1, 1, 0, 32'h100, 0, 32'h000));
        tbl.push_back(mk(0, 1, 1, 32'h100, 0, 32'h000));
        tbl.push_back(mk(0, 1, 1, 32'h104, 0, 32'h000));
        tbl.push_back(mk(0, 1, 1, 32'h108, 1, 32'h100));
        tbl.push_back(mk(0, 1, 1, 32'h10C, 1, 32'h104));
        tbl.push_back(mk(0, 1, 1, 32'h110, 1, 32'h108));
        tbl.push_back(mk(0, 1, 1, 32'h114, 1, 32'h10C));
        tbl.push_back(mk(1, 0, 0, 32'h118, 1, 32'h110));
        tbl.push_back(mk(0, 0, 1, 32'h100, 0, 32'h000));
        tbl.push_back(mk(0, 0, 1, 32'h104, 0, 32'h000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 32'h108, 1, 32'h100));
        tbl.push_back(mk(0, 1, 1, 32'h108, 1, 32'h100));
        tbl.push_back(mk(0, 1, 1, 32'h10C, 1, 32'h104));
        tbl.push_back(mk(0, 1, 1, 32'h110, 1, 32'h108));

        rst             = 1'b1;
        if_ready        = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        step();

        lat = 1;
        foreach (tbl[i]) begin
            rst      = tbl[i].rst;
            if_ready = tbl[i].ifr;
            pre();
            chk($sformatf("vec%0d.req_valid", i), imem_req_valid, tbl[i].rv);
            chk($sformatf("vec%0d.req_addr", i), imem_req_addr, tbl[i].ra);
            chk($sformatf("vec%0d.if_valid", i), if_valid, tbl[i].iv);
            chk($sformatf("vec%0d.if_pc", i), if_pc, tbl[i].pc);
            chk($sformatf("vec%0d.if_instr", i), if_instruction, tbl[i].pc);
            post();
        end

        // Redirect with two fetches in flight at 3-cycle latency.
        drain();
        rst = 1'b0; lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
        pre();
        chk("redir.req_valid_R", imem_req_valid, 1'b0);
        post();
        redirect_valid = 1'b0;
        pre();
        chk("redir.addr_R1", imem_req_addr, 32'h0000_2000);
        chk("redir.if_valid_R1", if_valid, 1'b0);
        post();
        wait_log(3, 40);
        chk_q("redir.log0_pc", log_pc, 0, 32'h2000);
        chk_q("redir.log0_ins", log_ins, 0, 32'h2000);
        chk_q("redir.log1_pc", log_pc, 1, 32'h2004);
        chk_q("redir.log2_pc", log_pc, 2, 32'h2008);
        chk_q("redir.acc2", acc_q, 2, 32'h2000);

        // Redirect in the same cycle as the response for 0x104.
        drain();
        rst = 1'b0; lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        pre();
        chk("coinc.resp_data", imem_resp_valid ? imem_resp_data : 32'hDEAD_BEEF, 32'h104);
        post();
        redirect_valid = 1'b0;
        pre();
        chk("coinc.if_valid_R1", if_valid, 1'b0);
        chk("coinc.req_valid_R1", imem_req_valid, 1'b1);
        chk("coinc.addr_R1", imem_req_addr, 32'h400);
        post();
        wait_log(4, 40);
        chk_q("coinc.log0", log_pc, 0, 32'h100);
        chk_q("coinc.log1", log_pc, 1, 32'h400);
        chk_q("coinc.log2", log_pc, 2, 32'h404);
        chk_q("coinc.log3", log_pc, 3, 32'h408);
        chk_q("coinc.log3_ins", log_ins, 3, 32'h408);

        // Address wrap with a stalling memory.
        drain();
        rst = 1'b0; lat = 1; if_ready = 1'b1; imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        pat        = 24'b1111_0110_1011_0100_1101_0100;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        for (int i = 0; i < 24; i++) begin
            imem_req_ready = pat[i];
            pre();
            if (prev_stall) chk($sformatf("wrap.hold%0d", i), imem_req_addr, prev_addr);
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            post();
        end
        chk_q("wrap.acc0", acc_q, 0, 32'hFFFF_FFFC);
        chk_q("wrap.acc1", acc_q, 1, 32'h0000_0000);
        chk_q("wrap.acc2", acc_q, 2, 32'h0000_0004);
        chk_q("wrap.acc3", acc_q, 3, 32'h0000_0008);
        chk_q("wrap.log0", log_pc, 0, 32'hFFFF_FFFC);
        chk_q("wrap.log1", log_pc, 1, 32'h0000_0000);
        chk_q("wrap.log1_ins", log_ins, 1, 32'h0000_0000);
        chk_q("wrap.log2", log_pc, 2, 32'h0000_0004);

        // Reset with a full buffer, then with two fetches outstanding.
        drain();
        rst = 1'b0; lat = 3; imem_req_ready = 1'b1; if_ready = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        pre();
        chk("rstmid.full_valid", if_valid, 1'b1);
        chk("rstmid.full_pc", if_pc, 32'h100);
        post();
        rst = 1'b0;
        pre();
        chk("rstmid.if_valid", if_valid, 1'b0);
        chk("rstmid.addr", imem_req_addr, RST_PC);
        chk("rstmid.req_valid", imem_req_valid, 1'b1);
        post();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; imem_req_ready = 1'b0;
        pre();
        chk("rstout.if_valid0", if_valid, 1'b0);
        chk("rstout.addr", imem_req_addr, RST_PC);
        post();
        pre();
        chk("rstout.if_valid1", if_valid, 1'b0);
        post();
        imem_req_ready = 1'b1; if_ready = 1'b1;
        pre();
        chk("rstout.if_valid2", if_valid, 1'b0);
        post();
        wait_log(2, 40);
        chk_q("rstout.log0", log_pc, 0, 32'h100);
        chk_q("rstout.log0_ins", log_ins, 0, 32'h100);
        chk_q("rstout.log1", log_pc, 1, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of each Xenyx-4 core. Holds the program counter and issues word-aligned requests to instruction memory over a valid/ready channel. Returns in-order responses to decode through a small credit-managed FIFO. Decode slices `if_instruction` and passes it to the immediate generator. Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] ignored.
- `FIFO_DEPTH`, 2: response buffer entries, power of two, ≥2; also the cap on in-flight + buffered fetches.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output 32: fetch address, always [1:0]=00.
- `imem_req_ready` input 1: memory accepts request this cycle.
- `imem_resp_valid` input 1: one response per accepted request, in order, ≥1 cycle after acceptance.
- `imem_resp_data` input 32: instruction word.
- `redirect_valid` input 1: branch/jump taken; single-cycle pulse.
- `redirect_pc` input 32: new fetch target; [1:0] forced to 00.
- `if_valid` output 1: FIFO head valid toward decode.
- `if_instruction` output 32: FIFO head instruction.
- `if_pc` output 32: address the head instruction was fetched from.
- `if_ready` input 1: decode consumes head when `if_valid & if_ready`.

## Operation
- State: `pc`, `outstanding` (accepted, unanswered), `drop` (stale responses to discard), FIFO of {pc, instruction} of depth FIFO_DEPTH, and an in-flight PC queue of depth FIFO_DEPTH that pairs each response with its address.
- Credit rule: `imem_req_valid = !rst & !redirect_valid & (outstanding + count - pop < FIFO_DEPTH)`, where pop = `if_valid & if_ready`.
- Request accept: on `imem_req_valid & imem_req_ready`, push `pc` to the PC queue, `pc <= pc + 4` (wraps mod 2^32), and `outstanding++`.
- Response: on `imem_resp_valid`, `outstanding--` and pop the PC queue. If `drop > 0`, decrement `drop` and discard the data. Otherwise push {queued pc, data} into the FIFO.
- Redirect (`redirect_valid`):
  - `pc <= redirect_pc & ~3`.
  - FIFO flushed.
  - No request issued this cycle.
  - A response arriving this cycle is discarded.
  - `drop <= outstanding - imem_resp_valid`.
  - The PC queue is retained for matching only.
- Redirect while `drop > 0`: `drop` is recomputed by the same formula, so all pre-redirect fetches stay stale.
- Same-cycle events:
  - Push and pop may occur together; count is unchanged.
  - Request accept and response may occur together; `outstanding` is unchanged.
- A response with `outstanding == 0` is a protocol violation. It is ignored and no state changes.
- `rst` overrides redirect and all handshakes.

## Timing
- Reset values:
  - `pc = RESET_PC`, so `imem_req_addr = RESET_PC`.
  - `imem_req_valid = 0`, `if_valid = 0`, `if_instruction = 0`, `if_pc = 0`.
  - `outstanding = 0`, `drop = 0`, FIFO empty.
- First request: `imem_req_valid = 1` in the first cycle with `rst` low.
- Response to decode: a response arriving in cycle N is visible on `if_valid` in cycle N+1. No combinational path from `imem_resp_*` to `if_*`.
- Throughput: with 1-cycle memory latency, `imem_req_ready` and `if_ready` held high, and FIFO_DEPTH=2, the unit sustains one instruction per cycle after a 2-cycle fill.
- Redirect: `if_valid = 0` in cycle R+1 (R = redirect cycle). The first request to the target is issued in cycle R+1.
- Backpressure: with `if_ready` low, at most FIFO_DEPTH requests are in flight plus buffered. The FIFO never overflows.

## Test plan
- Reset and stream:
  - Stimulus: `RESET_PC` = 0x100; memory at 1-cycle latency returns the address as data; `if_ready` high.
  - Required: `if_pc`/`if_instruction` = 0x100, 0x104, 0x108… on consecutive cycles after fill; no gaps.
- Backpressure:
  - Stimulus: hold `if_ready` low for 10 cycles.
  - Required: exactly 2 requests issued; `if_valid` high with head 0x100 steady. On release, 0x100, 0x104, 0x108 follow in order with none lost or duplicated.
- Redirect with in-flight fetches:
  - Stimulus: memory latency 3; after 2 outstanding requests, pulse redirect to 0x2002.
  - Required: next `imem_req_addr` = 0x2000; the 2 stale responses are discarded; first `if_pc` after the redirect = 0x2000.
- Redirect coincident with a response:
  - Stimulus: response for 0x104 arrives in the same cycle as a redirect to 0x400.
  - Required: 0x104 is never presented on `if_*`; `drop` equals the remaining outstanding count.
- Memory stall plus wrap:
  - Stimulus: `imem_req_ready` randomly low; start with `pc` = 0xFFFF_FFFC.
  - Required: the address stays stable while `imem_req_valid` is held without acceptance; the next address after 0xFFFF_FFFC is 0x0000_0000.
- Reset mid-operation:
  - Stimulus: assert `rst` with a full FIFO and 2 requests outstanding.
  - Required: next cycle `if_valid = 0` and `imem_req_addr = RESET_PC`. Stale responses arriving after reset are ignored.
